// File: rtl/vga_ctrl.sv
// ---------------------------------------------------------------------------
// vga_ctrl -- VGA timing generator for 640x480@60 Hz (25 MHz pixel clock).
//
// Two free-running counters (cnt_h per clock, cnt_v per line) are the only
// state. Every output is a combinational decode of those counters plus the
// pixel returned by the downstream pixel stage.
//
// The pixel stage has a single-cycle registered latency. For that reason
// pix_x/pix_y are requested one clock before the matching pixel is shown on
// rgb.
//
// Ports:
//   vga_clk      in   1   pixel clock, 25 MHz
//   rst_n        in   1   asynchronous, active-low reset
//   pix_data     in  16   RGB565 pixel, valid one clock after its pix_x/pix_y
//   pix_x        out 10   requested column, 10'h3FF outside the request window
//   pix_y        out 10   requested row, 10'h3FF outside the request window
//   hsync        out  1   horizontal sync, active level = SYNC_POL
//   vsync        out  1   vertical sync, active level = SYNC_POL
//   rgb_valid    out  1   high inside the active display window
//   rgb          out 16   pix_data when rgb_valid, else 16'h0000
//   frame_start  out  1   high while cnt_h == 0 and cnt_v == 0
// ---------------------------------------------------------------------------
module vga_ctrl #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_VALID  = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_VALID  = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int unsigned HS      = H_SYNC + H_BACK;
  localparam int unsigned VS      = V_SYNC + V_BACK;

  // All decode thresholds are pre-sized to the 10-bit counter width.
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_FIRST = 10'(HS);
  localparam logic [9:0] H_ACT_LAST  = 10'(HS + H_VALID - 1);
  localparam logic [9:0] H_REQ_FIRST = 10'(HS - 1);
  localparam logic [9:0] H_REQ_LAST  = 10'(HS + H_VALID - 2);
  localparam logic [9:0] V_ACT_FIRST = 10'(VS);
  localparam logic [9:0] V_ACT_LAST  = 10'(VS + V_VALID - 1);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       v_act;
  logic       h_act;
  logic       h_req;
  logic       req;

  // cnt_v advances on the same edge that wraps cnt_h, so a frame wrap
  // clears both counters together.
  // NOTE: non-blocking assignments keep every register update reading the
  // pre-edge values of cnt_h/cnt_v, independent of statement order.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      if (cnt_v == V_LAST) begin
        cnt_v <= '0;
      end else begin
        cnt_v <= cnt_v + 10'd1;
      end
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  // The request window is the active window shifted one clock earlier.
  // The pixel fetched for pix_x arrives on pix_data exactly when
  // rgb_valid covers that column.
  // NOTE: every output gets a default at the top of the block. A path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    v_act       = 1'b0;
    h_act       = 1'b0;
    h_req       = 1'b0;
    req         = 1'b0;
    pix_x       = 10'h3FF;
    pix_y       = 10'h3FF;
    hsync       = ~SYNC_POL;
    vsync       = ~SYNC_POL;
    rgb_valid   = 1'b0;
    rgb         = 16'h0000;
    frame_start = 1'b0;

    v_act = (cnt_v >= V_ACT_FIRST) && (cnt_v <= V_ACT_LAST);
    h_act = (cnt_h >= H_ACT_FIRST) && (cnt_h <= H_ACT_LAST);
    h_req = (cnt_h >= H_REQ_FIRST) && (cnt_h <= H_REQ_LAST);
    req   = v_act && h_req;

    if (cnt_h < H_SYNC_END) begin
      hsync = SYNC_POL;
    end
    if (cnt_v < V_SYNC_END) begin
      vsync = SYNC_POL;
    end

    // The subtractions only run inside req, where the counters sit at or
    // above their offsets, so they never wrap.
    if (req) begin
      pix_x = cnt_h - H_REQ_FIRST;
      pix_y = cnt_v - V_ACT_FIRST;
    end

    rgb_valid = v_act && h_act;
    if (rgb_valid) begin
      rgb = pix_data;
    end

    frame_start = (cnt_h == 10'd0) && (cnt_v == 10'd0);
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_ctrl -- directed self-checking bench for vga_ctrl.
//
// Three instances share vga_clk and rst_n:
//   u_dut   default timing, SYNC_POL=0
//   u_pol   default timing, SYNC_POL=1
//   u_small default horizontal timing with a short vertical frame of
//           2+3+4+2 = 11 lines. Its frame wrap, last active line and
//           vsync period are reachable within a short run.
//
// Each instance sees a registered pixel stage that returns 16'hA000 | pix_x,
// or 16'hFFFF while force_ff is set.
//
// The bench keeps its own reference counters (m_h, m_v, ms_v). A negedge
// monitor compares every output of every instance against values decoded
// from those counters. Directed checks cover reset, sync timing, the window
// boundaries, the pixel stream and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_vga_ctrl;

  localparam int WAIT_LIMIT = 30000;

  logic vga_clk  = 1'b0;
  logic rst_n    = 1'b0;
  logic force_ff = 1'b0;

  always #20 vga_clk = ~vga_clk;

  // ---- DUT signals ----
  logic [15:0] d_pix_data = 16'h0000;
  logic [15:0] p_pix_data = 16'h0000;
  logic [15:0] s_pix_data = 16'h0000;
  logic [9:0]  d_pix_x, d_pix_y, p_pix_x, p_pix_y, s_pix_x, s_pix_y;
  logic        d_hsync, d_vsync, d_rgb_valid, d_frame_start;
  logic        p_hsync, p_vsync, p_rgb_valid, p_frame_start;
  logic        s_hsync, s_vsync, s_rgb_valid, s_frame_start;
  logic [15:0] d_rgb, p_rgb, s_rgb;

  vga_ctrl u_dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .pix_data(d_pix_data),
    .pix_x(d_pix_x), .pix_y(d_pix_y), .hsync(d_hsync), .vsync(d_vsync),
    .rgb_valid(d_rgb_valid), .rgb(d_rgb), .frame_start(d_frame_start)
  );

  vga_ctrl #(.SYNC_POL(1'b1)) u_pol (
    .vga_clk(vga_clk), .rst_n(rst_n), .pix_data(p_pix_data),
    .pix_x(p_pix_x), .pix_y(p_pix_y), .hsync(p_hsync), .vsync(p_vsync),
    .rgb_valid(p_rgb_valid), .rgb(p_rgb), .frame_start(p_frame_start)
  );

  vga_ctrl #(.V_BACK(3), .V_VALID(4), .V_FRONT(2)) u_small (
    .vga_clk(vga_clk), .rst_n(rst_n), .pix_data(s_pix_data),
    .pix_x(s_pix_x), .pix_y(s_pix_y), .hsync(s_hsync), .vsync(s_vsync),
    .rgb_valid(s_rgb_valid), .rgb(s_rgb), .frame_start(s_frame_start)
  );

  // ---- pixel stage models: one-cycle registered latency ----
  always @(posedge vga_clk) begin
    d_pix_data <= force_ff ? 16'hFFFF : (16'hA000 | {6'd0, d_pix_x});
    p_pix_data <= force_ff ? 16'hFFFF : (16'hA000 | {6'd0, p_pix_x});
    s_pix_data <= force_ff ? 16'hFFFF : (16'hA000 | {6'd0, s_pix_x});
  end

  // ---- reference counters ----
  int m_h  = 0;
  int m_v  = 0;
  int ms_v = 0;

  always @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h  <= 0;
      m_v  <= 0;
      ms_v <= 0;
    end else if (m_h == 799) begin
      m_h  <= 0;
      m_v  <= (m_v == 524) ? 0 : m_v + 1;
      ms_v <= (ms_v == 10) ? 0 : ms_v + 1;
    end else begin
      m_h <= m_h + 1;
    end
  end

  // ---- checking ----
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (m_h=%0d m_v=%0d)", tag, got, exp, m_h, m_v);
    end
  endtask

  // Expected {hsync, vsync, rgb_valid, pix_x, pix_y, frame_start, rgb} for
  // the default horizontal timing. vs/vval are the first active line and the
  // number of active lines.
  function automatic logic [39:0] exp_vec(input int h, input int v, input int vs,
                                          input int vval, input bit pol,
                                          input logic [15:0] pq);
    logic       act, valid, req, hs, vsy, fs;
    logic [9:0] px, py;
    logic [15:0] rgb;
    act   = (v >= vs) && (v <= vs + vval - 1);
    valid = act && (h >= 144) && (h <= 783);
    req   = act && (h >= 143) && (h <= 782);
    px    = req ? 10'(h - 143) : 10'h3FF;
    py    = req ? 10'(v - vs)  : 10'h3FF;
    hs    = (h < 96) ? pol : ~pol;
    vsy   = (v < 2)  ? pol : ~pol;
    fs    = (h == 0) && (v == 0);
    rgb   = valid ? pq : 16'h0000;
    return {hs, vsy, valid, px, py, fs, rgb};
  endfunction

  int err_d = 0;
  int err_p = 0;
  int err_s = 0;

  always @(negedge vga_clk) begin
    if ({d_hsync, d_vsync, d_rgb_valid, d_pix_x, d_pix_y, d_frame_start, d_rgb}
        !== exp_vec(m_h, m_v, 35, 480, 1'b0, d_pix_data)) err_d++;
    if ({p_hsync, p_vsync, p_rgb_valid, p_pix_x, p_pix_y, p_frame_start, p_rgb}
        !== exp_vec(m_h, m_v, 35, 480, 1'b1, p_pix_data)) err_p++;
    if ({s_hsync, s_vsync, s_rgb_valid, s_pix_x, s_pix_y, s_frame_start, s_rgb}
        !== exp_vec(m_h, ms_v, 5, 4, 1'b0, s_pix_data)) err_s++;
  end

  // ---- helpers ----
  task automatic wait_d(input int h, input int v, input string tag);
    int n = 0;
    do begin
      @(negedge vga_clk);
      n++;
    end while (!(m_h == h && m_v == v) && n < WAIT_LIMIT);
    check({tag, "_timeout"}, 32'(n >= WAIT_LIMIT), 32'd0);
  endtask

  task automatic wait_s(input int h, input int v, input string tag);
    int n = 0;
    do begin
      @(negedge vga_clk);
      n++;
    end while (!(m_h == h && ms_v == v) && n < WAIT_LIMIT);
    check({tag, "_timeout"}, 32'(n >= WAIT_LIMIT), 32'd0);
  endtask

  function automatic logic sel_sig(input bit sel);
    return sel ? s_vsync : d_hsync;
  endfunction

  // sel=0: u_dut hsync, sel=1: u_small vsync. Finds a falling edge and
  // measures the cycles to the next one. It also counts the low samples
  // and the u_small frame_start samples in between.
  task automatic measure(input bit sel, output int period, output int low,
                         output int fs, output bit to);
    logic prev, cur;
    int   n = 0;
    to = 1'b0; period = 0; low = 0; fs = 0;
    prev = sel_sig(sel);
    cur  = prev;
    while (1) begin
      @(negedge vga_clk);
      cur = sel_sig(sel);
      n++;
      if (prev && !cur) break;
      prev = cur;
      if (n > WAIT_LIMIT) begin
        to = 1'b1;
        break;
      end
    end
    while (!to) begin
      if (!cur) low++;
      if (s_frame_start) fs++;
      prev = cur;
      @(negedge vga_clk);
      cur = sel_sig(sel);
      period++;
      if (prev && !cur) break;
      if (period > WAIT_LIMIT) to = 1'b1;
    end
  endtask

  // ---- directed sequence ----
  initial begin
    int  period, low, fs, col, errs, n;
    bit  to;

    // Reset state, SYNC_POL=0 and SYNC_POL=1.
    rst_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    check("rst_hsync",   32'(d_hsync),       32'd0);
    check("rst_vsync",   32'(d_vsync),       32'd0);
    check("rst_valid",   32'(d_rgb_valid),   32'd0);
    check("rst_rgb",     32'(d_rgb),         32'd0);
    check("rst_pix_x",   32'(d_pix_x),       32'h3FF);
    check("rst_pix_y",   32'(d_pix_y),       32'h3FF);
    check("rst_fs",      32'(d_frame_start), 32'd1);
    check("rst_pol_hs",  32'(p_hsync),       32'd1);
    check("rst_pol_vs",  32'(p_vsync),       32'd1);

    // First edge after release takes cnt_h to 1.
    rst_n = 1'b1;
    @(negedge vga_clk);
    check("rel_fs",      32'(d_frame_start), 32'd0);
    check("rel_hsync",   32'(d_hsync),       32'd0);

    wait_d(95, 0, "hs_last_low");
    check("hs_at_95",    32'(d_hsync), 32'd0);
    @(negedge vga_clk);
    check("hs_at_96",    32'(d_hsync), 32'd1);

    measure(1'b0, period, low, fs, to);
    check("hs_meas_to",  32'(to),     32'd0);
    check("hs_period",   32'(period), 32'd800);
    check("hs_low",      32'(low),    32'd96);

    // Short-frame instance: vsync period, width, and one frame_start.
    measure(1'b1, period, low, fs, to);
    check("vs_meas_to",  32'(to),     32'd0);
    check("vs_period",   32'(period), 32'd8800);
    check("vs_low",      32'(low),    32'd1600);
    check("vs_fs_count", 32'(fs),     32'd1);

    // Last active line and frame wrap on the short-frame instance.
    wait_s(143, 8, "s_last_line");
    check("s_pix_x_143", 32'(s_pix_x), 32'd0);
    check("s_pix_y_143", 32'(s_pix_y), 32'd3);
    check("s_valid_143", 32'(s_rgb_valid), 32'd0);
    wait_s(783, 8, "s_last_px");
    check("s_valid_783", 32'(s_rgb_valid), 32'd1);
    check("s_pix_x_783", 32'(s_pix_x), 32'h3FF);
    check("s_rgb_783",   32'(s_rgb), 32'hA27F);
    wait_s(143, 9, "s_front");
    check("s_pix_y_blk", 32'(s_pix_y), 32'h3FF);
    wait_s(799, 10, "s_wrap");
    check("s_fs_799",    32'(s_frame_start), 32'd0);
    check("s_vs_799",    32'(s_vsync), 32'd1);
    @(negedge vga_clk);
    check("s_fs_wrap",   32'(s_frame_start), 32'd1);
    check("s_vs_wrap",   32'(s_vsync), 32'd0);

    // First active line of the default instance: window edges and stream.
    wait_d(143, 35, "first_line");
    check("pix_x_143",   32'(d_pix_x), 32'd0);
    check("pix_y_143",   32'(d_pix_y), 32'd0);
    check("valid_143",   32'(d_rgb_valid), 32'd0);
    col  = 0;
    errs = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge vga_clk);
      if (d_rgb_valid) begin
        if (d_rgb !== 16'(16'hA000 + col)) errs++;
        col++;
      end
      if (m_h == 144) check("valid_144", 32'(d_rgb_valid), 32'd1);
      if (m_h == 782) check("pix_x_782", 32'(d_pix_x), 32'd639);
      if (m_h == 783) begin
        check("pix_x_783", 32'(d_pix_x), 32'h3FF);
        check("valid_783", 32'(d_rgb_valid), 32'd1);
      end
      if (m_h == 784) check("valid_784", 32'(d_rgb_valid), 32'd0);
    end
    check("col_seq_errs", 32'(errs), 32'd0);
    check("col_count",    32'(col),  32'd640);

    // rgb is gated off outside the window even with an all-ones pixel.
    wait_d(100, 36, "ff_line");
    force_ff = 1'b1;
    wait_d(143, 36, "ff_143");
    check("ff_rgb_143",  32'(d_rgb), 32'd0);
    check("ff_pix_y",    32'(d_pix_y), 32'd1);
    wait_d(200, 36, "ff_200");
    check("ff_rgb_200",  32'(d_rgb), 32'hFFFF);
    wait_d(784, 36, "ff_784");
    check("ff_rgb_784",  32'(d_rgb), 32'd0);
    force_ff = 1'b0;

    // Reset mid-line: outputs drop to reset values without a clock edge.
    wait_d(400, 37, "mid_reset");
    check("pre_rst_valid", 32'(d_rgb_valid), 32'd1);
    #5 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(d_rgb_valid),   32'd0);
    check("mid_rst_rgb",   32'(d_rgb),         32'd0);
    check("mid_rst_pix_x", 32'(d_pix_x),       32'h3FF);
    check("mid_rst_pix_y", 32'(d_pix_y),       32'h3FF);
    check("mid_rst_hsync", 32'(d_hsync),       32'd0);
    check("mid_rst_vsync", 32'(d_vsync),       32'd0);
    check("mid_rst_fs",    32'(d_frame_start), 32'd1);
    check("mid_rst_s_fs",  32'(s_frame_start), 32'd1);
    repeat (3) @(negedge vga_clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge vga_clk);
      n++;
    end while (!d_hsync && n < 2000);
    check("post_rst_hs_low", 32'(n), 32'd96);
    measure(1'b0, period, low, fs, to);
    check("post_rst_meas_to", 32'(to),     32'd0);
    check("post_rst_period",  32'(period), 32'd800);

    // Cycle-by-cycle monitor totals for all three instances.
    check("mon_dut_errs",   32'(err_d), 32'd0);
    check("mon_pol_errs",   32'(err_p), 32'd0);
    check("mon_small_errs", 32'(err_s), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
